que_scheduler: RTL and testbench
================================

Name: que_scheduler

Overview:
- Control stage directly downstream of que_arbitrator in the multi-port cache output path.
- Snapshots per-port queue pending/priority into the arbitrator (update), takes the granted port, and runs a read handshake with the packet-read engine for that port.
- On read completion or watchdog timeout, clears the granted port in the arbitrator and fetches the next grant; re-snapshots when the round is empty.

Parameters:
- PORTNUM, 16, number of input ports/queues.
- PRIOR, 8, number of priority levels.
- TIMEOUT, 1024, watchdog limit in cycles per read, counted from RD_REQ entry; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  scheduler enable; sampled in IDLE and CLR.
- i_que_pend  in  PORTNUM  per-port queue non-empty flags.
- i_que_prior  in  $clog2(PRIOR) x PORTNUM  per-port head-packet priority; passed through.
- o_arb_pending  out  PORTNUM  equals i_que_pend, combinational.
- o_arb_prior  out  $clog2(PRIOR) x PORTNUM  equals i_que_prior, combinational.
- o_arb_update  out  1  one-cycle snapshot pulse to the arbitrator.
- o_arb_clr_port  out  $clog2(PORTNUM)  port to clear.
- o_arb_clr_vld  out  1  one-cycle clear pulse.
- i_arb_port  in  $clog2(PORTNUM)  arbitrator grant.
- i_arb_port_vld  in  1  grant valid; arrives exactly 1 cycle after update or clear.
- i_arb_empty  in  1  arbitrator has no pending ports.
- o_rd_req  out  1  read request to the packet-read engine.
- o_rd_port  out  $clog2(PORTNUM)  port to read; stable while o_rd_req is high.
- i_rd_ack  in  1  request accepted.
- i_rd_done  in  1  one-cycle pulse: packet fully read.
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SNAP, WAIT_ARB, RD_REQ, RD_WAIT, CLR. All state-derived outputs are decoded from registered state and grant_port; there are no combinational paths from inputs to these outputs.
- Reset: state=IDLE; grant_port=0; watchdog count=0. o_arb_update, o_arb_clr_vld, o_rd_req, o_timeout and o_busy are 0; o_arb_clr_port=0 and o_rd_port=0.
- IDLE: if i_en && |i_que_pend, go to SNAP; otherwise stay.
- SNAP: o_arb_update=1 for exactly 1 cycle, then WAIT_ARB.
- WAIT_ARB lasts exactly 1 cycle.
  - If i_arb_port_vld: grant_port<=i_arb_port, then RD_REQ.
  - Otherwise (arbitrator empty): go to IDLE.
  - i_arb_port_vld is ignored in every other state.
- RD_REQ: o_rd_req=1 and o_rd_port=grant_port until i_rd_ack, then RD_WAIT. If i_rd_ack and i_rd_done arrive in the same cycle, go straight to CLR.
- RD_WAIT: on i_rd_done, go to CLR.
- Watchdog:
  - Count clears on entry to RD_REQ and increments in RD_REQ and RD_WAIT.
  - When count==TIMEOUT-1 with no i_rd_done that cycle: o_timeout pulses for 1 cycle, o_rd_req drops, state goes to CLR.
  - i_rd_done in the same cycle as expiry wins: no timeout.
  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- CLR: o_arb_clr_vld=1 and o_arb_clr_port=grant_port for 1 cycle.
  - If i_en is high, go to WAIT_ARB, which samples the arbitrator's next grant.
  - If i_en is low, go to IDLE; later work requires a fresh SNAP.
- Round latency: pending seen in IDLE → update pulse +1 → grant captured +2 → o_rd_req asserted +3.
- Per-packet overhead after i_rd_done: CLR +1, WAIT_ARB +2, next o_rd_req +3.
- i_en deassertion only takes effect in IDLE and CLR; an in-flight read always completes or times out.
- Reset mid-read: all outputs return to reset values asynchronously. No clear is issued; the arbitrator is reset by the same i_rst_n.
- i_arb_empty is used for assertion only: i_arb_port_vld && i_arb_empty must never occur.

Decomposition:
- Shared package mpc_sched_pkg:
  - PORT_W=$clog2(PORTNUM) and PRIO_W=$clog2(PRIOR) localparams.
  - sched_state_t enum {IDLE,SNAP,WAIT_ARB,RD_REQ,RD_WAIT,CLR}.
- One sub-module, que_sched_wdog: parameterised saturating counter with clear/enable inputs and an expiry output; it ties expiry off when TIMEOUT=0.

Test Plan:
- Pending 0x0000, i_en=1 for 50 cycles → stays IDLE; o_arb_update never pulses; o_busy=0.
- Pending 0x0005. Arbitrator grants 2, then 0, then empty. i_rd_ack is immediate and i_rd_done arrives 10 cycles after the ack.
  - Required: o_rd_port=2, then 0.
  - Clear pulses carry ports 2 then 0.
  - Exactly one update pulse before the grants; return to IDLE when the stub reports empty.
  - Timing: o_rd_req 3 cycles after pending is seen; next o_rd_req 3 cycles after i_rd_done.
- TIMEOUT=16, grant port 7, i_rd_ack given, i_rd_done never arrives → o_timeout pulses 16 cycles after RD_REQ entry; o_arb_clr_port=7 the following cycle.
- TIMEOUT=16, i_rd_done on exactly the expiry cycle → no o_timeout; normal clear of the port.
- Drop i_en during RD_WAIT with pending 0x00FF → the current read completes, CLR is issued, then IDLE; no further o_rd_req.
- Assert i_rst_n=0 while o_rd_req=1 → o_rd_req, o_busy and o_arb_clr_vld fall to 0 immediately; after release, a fresh SNAP occurs.

Source files
------------

// File: rtl/mpc_sched_pkg.sv
//------------------------------------------------------------------------------
// Module : mpc_sched_pkg
// Brief  : Shared widths and state encoding for the output-path scheduler.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mpc_sched_pkg;

    localparam int PORTNUM_DEF = 16;
    localparam int PRIOR_DEF   = 8;
    localparam int PORT_W      = $clog2(PORTNUM_DEF);
    localparam int PRIO_W      = $clog2(PRIOR_DEF);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNAP     = 3'd1,
        WAIT_ARB = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        CLR      = 3'd5
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/que_sched_wdog.sv
//------------------------------------------------------------------------------
// Module : que_sched_wdog
// Brief  : Saturating per-read watchdog; expiry ties off when TIMEOUT is 0.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module que_sched_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [c_cnt_w-1:0] r_cnt;

            // Holds at TIMEOUT so a stalled read can never wrap back to zero.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en && (r_cnt != c_cnt_w'(TIMEOUT))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_expired = i_en && (r_cnt == c_cnt_w'(TIMEOUT - 1));
        end else begin : g_no_wdog
            logic w_unused;
            assign w_unused  = ^{i_clk, i_rst_n, i_clr, i_en};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/que_scheduler.sv
//------------------------------------------------------------------------------
// Module : que_scheduler
// Brief  : Sequences arbitrator snapshot/grant/clear around packet-read handshakes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module que_scheduler
    import mpc_sched_pkg::*;
#(
    parameter  int PORTNUM  = 16,
    parameter  int PRIOR    = 8,
    parameter  int TIMEOUT  = 1024,
    localparam int c_port_w = $clog2(PORTNUM),
    localparam int c_prio_w = $clog2(PRIOR)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic [PORTNUM-1:0]           i_que_pend,
    input  logic [c_prio_w*PORTNUM-1:0]  i_que_prior,
    output logic [PORTNUM-1:0]           o_arb_pending,
    output logic [c_prio_w*PORTNUM-1:0]  o_arb_prior,
    output logic                         o_arb_update,
    output logic [c_port_w-1:0]          o_arb_clr_port,
    output logic                         o_arb_clr_vld,
    input  logic [c_port_w-1:0]          i_arb_port,
    input  logic                         i_arb_port_vld,
    input  logic                         i_arb_empty,
    output logic                         o_rd_req,
    output logic [c_port_w-1:0]          o_rd_port,
    input  logic                         i_rd_ack,
    input  logic                         i_rd_done,
    output logic                         o_timeout,
    output logic                         o_busy
);

    sched_state_t          r_state;
    logic [c_port_w-1:0]   r_grant_port;
    logic                  r_timeout;
    logic                  w_expired;
    logic                  w_wd_clr;
    logic                  w_wd_en;

    assign w_wd_clr = (r_state == WAIT_ARB) && i_arb_port_vld;
    assign w_wd_en  = (r_state == RD_REQ) || (r_state == RD_WAIT);

    que_sched_wdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_grant_port <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en && (|i_que_pend)) r_state <= SNAP;
                end
                SNAP: begin
                    r_state <= WAIT_ARB;
                end
                WAIT_ARB: begin
                    if (i_arb_port_vld) begin
                        r_grant_port <= i_arb_port;
                        r_state      <= RD_REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_REQ: begin
                    // A completion landing on the expiry cycle beats the watchdog.
                    if (i_rd_ack && i_rd_done) begin
                        r_state <= CLR;
                    end else if (w_expired && !i_rd_done) begin
                        r_timeout <= 1'b1;
                        r_state   <= CLR;
                    end else if (i_rd_ack) begin
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i_rd_done) begin
                        r_state <= CLR;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= CLR;
                    end
                end
                CLR: begin
                    r_state <= i_en ? WAIT_ARB : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_arb_pending  = i_que_pend;
    assign o_arb_prior    = i_que_prior;
    assign o_arb_update   = (r_state == SNAP);
    assign o_arb_clr_vld  = (r_state == CLR);
    assign o_arb_clr_port = r_grant_port;
    assign o_rd_req       = (r_state == RD_REQ);
    assign o_rd_port      = r_grant_port;
    assign o_timeout      = r_timeout;
    assign o_busy         = (r_state != IDLE);

    a_no_grant_when_empty: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_arb_port_vld && i_arb_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_que_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_que_scheduler
// Brief  : Directed bench with arbitrator / read-engine stubs and event tables.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_que_scheduler;

    localparam int PORTNUM = 16;
    localparam int PRIOR   = 8;
    localparam int TIMEOUT = 16;

    localparam int K_UPD = 0;
    localparam int K_RDQ = 1;
    localparam int K_CLR = 2;
    localparam int K_TMO = 3;

    typedef struct {
        int sid;
        int rel;
        int kind;
        int port;
    } ev_t;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_en;
    logic [15:0]   i_que_pend;
    logic [47:0]   i_que_prior;
    logic [15:0]   o_arb_pending;
    logic [47:0]   o_arb_prior;
    logic          o_arb_update;
    logic [3:0]    o_arb_clr_port;
    logic          o_arb_clr_vld;
    logic [3:0]    i_arb_port;
    logic          i_arb_port_vld;
    logic          i_arb_empty;
    logic          o_rd_req;
    logic [3:0]    o_rd_port;
    logic          i_rd_ack;
    logic          i_rd_done;
    logic          o_timeout;
    logic          o_busy;

    que_scheduler #(
        .PORTNUM        (PORTNUM),
        .PRIOR          (PRIOR),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_que_pend     (i_que_pend),
        .i_que_prior    (i_que_prior),
        .o_arb_pending  (o_arb_pending),
        .o_arb_prior    (o_arb_prior),
        .o_arb_update   (o_arb_update),
        .o_arb_clr_port (o_arb_clr_port),
        .o_arb_clr_vld  (o_arb_clr_vld),
        .i_arb_port     (i_arb_port),
        .i_arb_port_vld (i_arb_port_vld),
        .i_arb_empty    (i_arb_empty),
        .o_rd_req       (o_rd_req),
        .o_rd_port      (o_rd_port),
        .i_rd_ack       (i_rd_ack),
        .i_rd_done      (i_rd_done),
        .o_timeout      (o_timeout),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    c0       = 0;
    int    dcnt     = 0;
    int    done_dly = 0;
    int    gidx     = 0;
    int    grants[$];
    bit    auto_ack  = 1'b1;
    bit    busy_seen = 1'b0;
    bit    prev_rdreq = 1'b0;
    ev_t   exp_tab[$];
    ev_t   log_q[$];
    logic [47:0] pv;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int enc(input ev_t e);
        return e.rel * 1000 + e.kind * 100 + e.port;
    endfunction

    function automatic void add_exp(input int sid, input int rel, input int kind, input int port);
        ev_t e;
        e.sid = sid; e.rel = rel; e.kind = kind; e.port = port;
        exp_tab.push_back(e);
    endfunction

    function automatic void log_ev(input int kind, input int port);
        ev_t e;
        e.sid = 0; e.rel = cyc - c0; e.kind = kind; e.port = port;
        log_q.push_back(e);
    endfunction

    // One clock: advance, then play the arbitrator and read-engine stubs.
    task automatic tick();
        logic prev_pulse;
        prev_pulse = o_arb_update | o_arb_clr_vld;
        @(posedge i_clk);
        #1;
        cyc++;
        if (prev_pulse) begin
            if (gidx < grants.size()) begin
                i_arb_port_vld = 1'b1;
                i_arb_port     = 4'(grants[gidx]);
                i_arb_empty    = 1'b0;
                gidx++;
            end else begin
                i_arb_port_vld = 1'b0;
                i_arb_empty    = 1'b1;
            end
        end else begin
            i_arb_port_vld = 1'b0;
        end
        if (dcnt > 0) begin
            dcnt--;
            i_rd_done = (dcnt == 0);
        end else begin
            i_rd_done = 1'b0;
        end
        i_rd_ack = auto_ack && o_rd_req;
        if (i_rd_ack && done_dly > 0) dcnt = done_dly;
        if (o_arb_update) log_ev(K_UPD, 0);
        if (o_rd_req && !prev_rdreq) log_ev(K_RDQ, int'(o_rd_port));
        if (o_arb_clr_vld) begin
            log_ev(K_CLR, int'(o_arb_clr_port));
            i_que_pend[o_arb_clr_port] = 1'b0;
        end
        if (o_timeout) log_ev(K_TMO, 0);
        if (o_busy) busy_seen = 1'b1;
        prev_rdreq = o_rd_req;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_scen(input logic [15:0] pend_v, input int dly);
        log_q.delete();
        c0          = cyc;
        gidx        = 0;
        dcnt        = 0;
        done_dly    = dly;
        busy_seen   = 1'b0;
        i_arb_empty = 1'b0;
        i_que_pend  = pend_v;
    endtask

    task automatic check_scen(input int sid, input string nm);
        ev_t e[$];
        foreach (exp_tab[i]) if (exp_tab[i].sid == sid) e.push_back(exp_tab[i]);
        chk($sformatf("%s_nevents", nm), log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk($sformatf("%s_ev%0d", nm, i), enc(log_q[i]), enc(e[i]));
    endtask

    initial begin
        // Expected event tables: {scenario, cycle relative to pending seen, kind, port}
        add_exp(2, 1,  K_UPD, 0);
        add_exp(2, 3,  K_RDQ, 2);
        add_exp(2, 14, K_CLR, 2);
        add_exp(2, 16, K_RDQ, 0);
        add_exp(2, 27, K_CLR, 0);
        add_exp(3, 1,  K_UPD, 0);
        add_exp(3, 3,  K_RDQ, 7);
        add_exp(3, 19, K_CLR, 7);
        add_exp(3, 19, K_TMO, 0);
        add_exp(4, 1,  K_UPD, 0);
        add_exp(4, 3,  K_RDQ, 3);
        add_exp(4, 19, K_CLR, 3);
        add_exp(5, 1,  K_UPD, 0);
        add_exp(5, 3,  K_RDQ, 4);
        add_exp(5, 14, K_CLR, 4);
        add_exp(6, 1,  K_UPD, 0);
        add_exp(6, 3,  K_RDQ, 1);
        add_exp(7, 1,  K_UPD, 0);
        add_exp(7, 3,  K_RDQ, 1);
        add_exp(7, 8,  K_CLR, 1);

        i_rst_n        = 1'b0;
        i_en           = 1'b0;
        i_que_pend     = '0;
        i_que_prior    = '0;
        i_arb_port     = '0;
        i_arb_port_vld = 1'b0;
        i_arb_empty    = 1'b0;
        i_rd_ack       = 1'b0;
        i_rd_done      = 1'b0;
        #12;
        chk("rst_update",   int'(o_arb_update),   0);
        chk("rst_clr_vld",  int'(o_arb_clr_vld),  0);
        chk("rst_rd_req",   int'(o_rd_req),       0);
        chk("rst_timeout",  int'(o_timeout),      0);
        chk("rst_busy",     int'(o_busy),         0);
        chk("rst_clr_port", int'(o_arb_clr_port), 0);
        chk("rst_rd_port",  int'(o_rd_port),      0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Pass-through and enable gating while idle
        pv          = 48'h9ABC_DEF0_1234;
        i_que_prior = pv;
        i_que_pend  = 16'h1234;
        #1;
        chk("pend_pass",    int'(o_arb_pending),   32'h1234);
        chk("prior_pass_lo", int'(o_arb_prior[31:0]),  int'(pv[31:0]));
        chk("prior_pass_hi", int'(o_arb_prior[47:32]), int'(pv[47:32]));
        busy_seen = 1'b0;
        run(4);
        chk("en_low_idle", int'(busy_seen), 0);
        i_que_pend = '0;
        i_en       = 1'b1;
        run(2);

        // 1: nothing pending
        grants = {};
        start_scen(16'h0000, 0);
        run(50);
        check_scen(1, "idle");
        chk("idle_busy_seen", int'(busy_seen), 0);

        // 2: two grants then empty
        grants = {2, 0};
        start_scen(16'h0005, 10);
        run(40);
        check_scen(2, "two_grants");
        chk("two_grants_end_busy", int'(o_busy), 0);

        // 3: watchdog expiry with no completion
        grants = {7};
        start_scen(16'h0080, 0);
        run(20);
        chk("tmo_clr_port_after", int'(o_arb_clr_port), 7);
        run(10);
        check_scen(3, "timeout");
        chk("timeout_end_busy", int'(o_busy), 0);

        // 4: completion on the expiry cycle
        grants = {3};
        start_scen(16'h0008, 15);
        run(30);
        check_scen(4, "done_at_expiry");

        // 5: enable dropped mid-read
        grants = {4, 5, 6};
        start_scen(16'h00FF, 10);
        run(5);
        i_en = 1'b0;
        run(35);
        check_scen(5, "en_drop");
        chk("en_drop_busy", int'(o_busy), 0);
        i_que_pend = '0;
        i_en       = 1'b1;
        run(3);

        // 6: asynchronous reset while requesting
        grants   = {1};
        auto_ack = 1'b0;
        start_scen(16'h0002, 4);
        run(5);
        chk("pre_rst_rd_req", int'(o_rd_req), 1);
        check_scen(6, "pre_rst");
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rd_req",  int'(o_rd_req),      0);
        chk("async_busy",    int'(o_busy),        0);
        chk("async_clr_vld", int'(o_arb_clr_vld), 0);
        chk("async_rd_port", int'(o_rd_port),     0);
        #1;
        i_rst_n  = 1'b1;
        auto_ack = 1'b1;
        grants   = {1};
        start_scen(16'h0002, 4);
        run(15);
        check_scen(7, "post_rst");
        chk("post_rst_busy", int'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
